// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and the ID decoder.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // SPECIAL-opcode funct field values decoded in ID
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate; purely combinational, no flow control.
module muldiv_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + {{(WIDTH-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 multiply/divide owning HI/LO; result WIDTH+1 edges after start.
// No backpressure: start while busy is ignored, so the pipeline must stall on busy_o.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             kill_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op, start_div, sa, sb;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign start_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign sa        = signed_op & src_a_i[WIDTH-1];
    assign sb        = signed_op & src_b_i[WIDTH-1];

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (.val_i(src_a_i), .neg_i(sa), .val_o(a_abs));
    muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (.val_i(src_b_i), .neg_i(sb), .val_o(b_abs));

    // Multiply: acc holds {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});

    // Divide: acc low half holds dividend bits shifting out and quotient bits shifting in
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opa_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opa_q;

    muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_prod (.val_i(acc_q), .neg_i(neg_res_q), .val_o(prod_fix));
    muldiv_abs #(.WIDTH(WIDTH)) u_fix_quo (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .val_o(quo_fix));
    muldiv_abs #(.WIDTH(WIDTH)) u_fix_rem (.val_i(rem_q), .neg_i(neg_rem_q), .val_o(rem_fix));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opa_d     = opa_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !kill_i) begin
                    state_d   = S_RUN;
                    cnt_d     = CW'(WIDTH - 1);
                    is_div_d  = start_div;
                    opa_d     = start_div ? b_abs : a_abs;
                    acc_d     = {{WIDTH{1'b0}}, (start_div ? a_abs : b_abs)};
                    rem_d     = '0;
                    // Divide-by-zero keeps an all-ones quotient regardless of dividend sign
                    neg_res_d = (sa ^ sb) & ~(start_div && (src_b_i == '0));
                    neg_rem_d = sa;
                end else if (!start_i && !kill_i) begin
                    if (wr_hi_i) hi_d = wr_data_i;
                    if (wr_lo_i) lo_d = wr_data_i;
                end
            end
            S_RUN: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                        rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!kill_i) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opa_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opa_q     <= opa_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk, rst;
    logic        start, kill, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wr_data;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        p_start, p_kill, p_wr_hi, p_wr_lo;
    logic [1:0]  p_op;
    logic [7:0]  p_a, p_b, p_wr_data;
    logic        p_busy, p_done;
    logic [7:0]  p_hi, p_lo;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int lat;
    int d0;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .src_a_i(a), .src_b_i(b), .kill_i(kill),
        .wr_hi_i(wr_hi), .wr_lo_i(wr_lo), .wr_data_i(wr_data),
        .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(p_start), .op_i(p_op),
        .src_a_i(p_a), .src_b_i(p_b), .kill_i(p_kill),
        .wr_hi_i(p_wr_hi), .wr_lo_i(p_wr_lo), .wr_data_i(p_wr_data),
        .busy_o(p_busy), .done_o(p_done), .hi_o(p_hi), .lo_o(p_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_seen++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
    endtask

    task automatic wait32(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic do32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
        start32(o, x, y);
        wait32(n);
    endtask

    task automatic do8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int n);
        p_start = 1'b1; p_op = o; p_a = x; p_b = y;
        tick();
        p_start = 1'b0;
        n = 0;
        while (p_busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 0; kill = 0; wr_hi = 0; wr_lo = 0; op = 0; a = 0; b = 0; wr_data = 0;
        p_start = 0; p_kill = 0; p_wr_hi = 0; p_wr_lo = 0; p_op = 0; p_a = 0; p_b = 0; p_wr_data = 0;
        #2;
        check("reset_hilo32", {hi, lo}, 64'h0);
        check("reset_busy_done32", {62'h0, busy, done}, 64'h0);
        check("reset_hilo8", {48'h0, p_hi, p_lo}, 64'h0);
        #10 rst = 1'b1;
        tick();

        d0 = done_seen;
        do32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        check("multu_busy_cycles", lat, 33);
        check("multu_done", done, 1);
        check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
        tick();
        check("multu_done_one_cycle", done_seen - d0, 1);

        do32(OP_MULT, 32'hFFFFFFFD, 32'd5, lat);
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        do32(OP_DIV, 32'hFFFFFFF9, 32'd2, lat);
        check("b2b_div_busy_cycles", lat, 33);
        check("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        do32(OP_DIVU, 32'd7, 32'd0, lat);
        check("divu_by_zero", {hi, lo}, 64'h00000007_FFFFFFFF);
        do32(OP_DIV, 32'hFFFFFFF9, 32'd0, lat);
        check("div_neg_by_zero", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
        do32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        check("div_overflow", {hi, lo}, 64'h00000000_80000000);

        wr_hi = 1'b1; wr_data = 32'hAAAA0000;
        tick();
        wr_hi = 1'b0;
        check("mthi", hi, 32'hAAAA0000);

        d0 = done_seen;
        wr_lo = 1'b1; wr_data = 32'h1234;
        start32(OP_MULTU, 32'd3, 32'd4);
        wr_lo = 1'b0;
        check("mtlo_dropped_on_start", lo, 32'h80000000);
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_busy_low", busy, 0);
        repeat (2) tick();
        check("kill_no_done", done_seen - d0, 0);
        check("kill_hilo_held", {hi, lo}, 64'hAAAA0000_80000000);

        start = 1'b1; kill = 1'b1; op = OP_MULTU;
        tick();
        start = 1'b0; kill = 1'b0;
        check("kill_beats_start", busy, 0);

        start32(OP_DIVU, 32'd100, 32'd7);
        repeat (4) tick();
        start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd3;
        tick();
        start = 1'b0;
        wait32(lat);
        check("start_while_busy_latency", lat, 28);
        check("start_while_busy_result", {hi, lo}, 64'h00000002_0000000E);

        start32(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("async_rst_hilo", {hi, lo}, 64'h0);
        check("async_rst_busy_done", {62'h0, busy, done}, 64'h0);
        tick();
        rst = 1'b1;
        tick();
        do32(OP_DIVU, 32'd1000, 32'd33, lat);
        check("after_rst_busy_cycles", lat, 33);
        check("after_rst_divu", {hi, lo}, 64'h0000000A_0000001E);

        do8(OP_MULTU, 8'hFF, 8'hFF, lat);
        check("w8_multu_busy_cycles", lat, 9);
        check("w8_multu_hilo", {48'h0, p_hi, p_lo}, 64'hFE01);
        do8(OP_DIV, 8'h80, 8'hFF, lat);
        check("w8_div_overflow", {48'h0, p_hi, p_lo}, 64'h0080);
        do8(OP_MULT, 8'hFD, 8'h05, lat);
        check("w8_mult_neg", {48'h0, p_hi, p_lo}, 64'hFFF1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
